// File: rtl/lc3_regfile_ctx.sv
// lc3_regfile_ctx: bypassed, scoreboarded LC-3 register file with a context save/restore stream engine.
// The save engine latches one register per SAVE_LD and presents it in SAVE_TX; restore writes R[idx] per si beat.
module lc3_regfile_ctx #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int AW     = $clog2(NREG),
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_drop_o,
   input  logic [AW-1:0]     rd0_addr_i,
   input  logic [AW-1:0]     rd1_addr_i,
   output logic [DATA_W-1:0] rd0_data_o,
   output logic [DATA_W-1:0] rd1_data_o,
   output logic              rd0_busy_o,
   output logic              rd1_busy_o,
   input  logic [AW-1:0]     dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   input  logic              iss_en_i,
   input  logic [AW-1:0]     iss_addr_i,
   output logic [NREG-1:0]   busy_vec_o,
   input  logic              ctx_save_i,
   input  logic              ctx_restore_i,
   output logic              ctx_busy_o,
   output logic              so_valid_o,
   input  logic              so_ready_i,
   output logic [AW-1:0]     so_addr_o,
   output logic [DATA_W-1:0] so_data_o,
   input  logic              si_valid_i,
   output logic              si_ready_o,
   input  logic [DATA_W-1:0] si_data_i
);
   typedef enum logic [1:0] {IDLE, SAVE_LD, SAVE_TX, RESTORE} state_t;
   localparam bit BP = BYPASS != 0;
   state_t state_q, state_d;
   logic [DATA_W-1:0] r_q [NREG];
   logic [DATA_W-1:0] r_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW-1:0] idx_q, idx_d, so_addr_q, so_addr_d;
   logic [DATA_W-1:0] so_data_q, so_data_d;
   logic restoring, wr_acc, iss_acc, si_fire, last, bp0, bp1;

   assign restoring  = state_q == RESTORE;
   assign wr_acc     = wr_en_i & ~restoring;
   assign iss_acc    = iss_en_i & ~restoring;
   assign si_fire    = restoring & si_valid_i;
   assign last       = idx_q == AW'(NREG - 1);
   assign wr_drop_o  = wr_en_i & restoring;
   assign bp0        = BP && wr_acc && wr_addr_i == rd0_addr_i;
   assign bp1        = BP && wr_acc && wr_addr_i == rd1_addr_i;
   assign rd0_data_o = bp0 ? wr_data_i : r_q[rd0_addr_i];
   assign rd1_data_o = bp1 ? wr_data_i : r_q[rd1_addr_i];
   assign rd0_busy_o = busy_q[rd0_addr_i] & ~bp0;
   assign rd1_busy_o = busy_q[rd1_addr_i] & ~bp1;
   assign dbg_data_o = r_q[dbg_addr_i];
   assign busy_vec_o = busy_q;
   assign ctx_busy_o = state_q != IDLE;
   assign so_valid_o = state_q == SAVE_TX;
   assign si_ready_o = restoring;
   assign so_addr_o  = so_addr_q;
   assign so_data_o  = so_data_q;

   // Issue is applied last so a same-cycle issue beats the clearing write.
   always_comb begin
      r_d    = r_q;
      busy_d = busy_q;
      if (wr_acc) begin
         r_d[wr_addr_i]    = wr_data_i;
         busy_d[wr_addr_i] = 1'b0;
      end
      if (si_fire) begin
         r_d[idx_q]    = si_data_i;
         busy_d[idx_q] = 1'b0;
      end
      if (iss_acc) busy_d[iss_addr_i] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      so_addr_d = so_addr_q;
      so_data_d = so_data_q;
      case (state_q)
         IDLE: begin
            idx_d   = '0;
            state_d = ctx_save_i ? SAVE_LD : ctx_restore_i ? RESTORE : IDLE;
         end
         SAVE_LD: begin
            so_data_d = (wr_acc && wr_addr_i == idx_q) ? wr_data_i : r_q[idx_q];
            so_addr_d = idx_q;
            state_d   = SAVE_TX;
         end
         SAVE_TX: if (so_ready_i) begin
            state_d = last ? IDLE : SAVE_LD;
            idx_d   = last ? idx_q : idx_q + 1'b1;
         end
         default: if (si_valid_i) begin
            state_d = last ? IDLE : RESTORE;
            idx_d   = last ? idx_q : idx_q + 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         so_addr_q <= '0;
         so_data_q <= '0;
         busy_q    <= '0;
         r_q       <= '{default: '0};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         so_addr_q <= so_addr_d;
         so_data_q <= so_data_d;
         busy_q    <= busy_d;
         r_q       <= r_d;
      end
   end
endmodule

// File: tb/tb_lc3_regfile_ctx.sv
// tb_lc3_regfile_ctx: randomized and directed checks of lc3_regfile_ctx against an array-based reference model.
module tb_lc3_regfile_ctx;
   logic clk = 1'b0, rst = 1'b1;
   logic wr_en, iss_en, ctx_save, ctx_restore, so_ready, si_valid;
   logic [2:0] wr_addr, rd0_addr, rd1_addr, dbg_addr, iss_addr;
   logic [15:0] wr_data, si_data;
   logic wr_drop, rd0_busy, rd1_busy, ctx_busy, so_valid, si_ready;
   logic [15:0] rd0_data, rd1_data, dbg_data, so_data;
   logic [2:0] so_addr;
   logic [7:0] busy_vec;
   logic b_wr_drop, b_rd0_busy, b_rd1_busy, b_ctx_busy, b_so_valid, b_si_ready;
   logic [15:0] b_rd0_data, b_rd1_data, b_dbg_data, b_so_data;
   logic [2:0] b_so_addr;
   logic [7:0] b_busy_vec;
   logic [15:0] m_r [8];
   logic [7:0] m_busy;
   int vec = 0, err = 0;

   always #5 clk = ~clk;

   lc3_regfile_ctx u0 (.clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_drop_o(wr_drop), .rd0_addr_i(rd0_addr), .rd1_addr_i(rd1_addr), .rd0_data_o(rd0_data),
      .rd1_data_o(rd1_data), .rd0_busy_o(rd0_busy), .rd1_busy_o(rd1_busy), .dbg_addr_i(dbg_addr),
      .dbg_data_o(dbg_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_vec_o(busy_vec),
      .ctx_save_i(ctx_save), .ctx_restore_i(ctx_restore), .ctx_busy_o(ctx_busy), .so_valid_o(so_valid),
      .so_ready_i(so_ready), .so_addr_o(so_addr), .so_data_o(so_data), .si_valid_i(si_valid),
      .si_ready_o(si_ready), .si_data_i(si_data));

   lc3_regfile_ctx #(.BYPASS(0)) u1 (.clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .wr_drop_o(b_wr_drop), .rd0_addr_i(rd0_addr), .rd1_addr_i(rd1_addr),
      .rd0_data_o(b_rd0_data), .rd1_data_o(b_rd1_data), .rd0_busy_o(b_rd0_busy), .rd1_busy_o(b_rd1_busy),
      .dbg_addr_i(dbg_addr), .dbg_data_o(b_dbg_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
      .busy_vec_o(b_busy_vec), .ctx_save_i(ctx_save), .ctx_restore_i(ctx_restore), .ctx_busy_o(b_ctx_busy),
      .so_valid_o(b_so_valid), .so_ready_i(so_ready), .so_addr_o(b_so_addr), .so_data_o(b_so_data),
      .si_valid_i(si_valid), .si_ready_o(b_si_ready), .si_data_i(si_data));

   task automatic idle_in();
      wr_en = 0; wr_addr = 0; wr_data = 0; rd0_addr = 0; rd1_addr = 0; dbg_addr = 0;
      iss_en = 0; iss_addr = 0; ctx_save = 0; ctx_restore = 0; so_ready = 0; si_valid = 0; si_data = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: accepted write stores and clears busy, then an issue sets busy.
   task automatic model_upd();
      if (wr_en) begin
         m_r[wr_addr] = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (iss_en) m_busy[iss_addr] = 1'b1;
   endtask

   task automatic model_rst();
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_busy = '0;
   endtask

   task automatic test_reset();
      idle_in();
      rst = 1;
      #3;
      vec++; if ({busy_vec, ctx_busy, so_valid, si_ready, wr_drop} !== 12'h0) begin err++;
         $display("FAIL reset_flags got %h exp 000", {busy_vec, ctx_busy, so_valid, si_ready, wr_drop}); end
      vec++; if ({so_addr, so_data} !== 19'h0) begin err++;
         $display("FAIL reset_so got %h exp 0", {so_addr, so_data}); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         vec++; if (dbg_data !== 16'h0) begin err++; $display("FAIL reset_r%0d got %h exp 0000", i, dbg_data); end
      end
      model_rst();
      @(negedge clk);
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
      @(negedge clk); model_upd(); tick();
      wr_en = 0; rd0_addr = 3; dbg_addr = 3;
      @(negedge clk);
      vec++; if (rd0_data !== 16'h1234) begin err++; $display("FAIL basic_rd0 got %h exp 1234", rd0_data); end
      vec++; if (dbg_data !== 16'h1234) begin err++; $display("FAIL basic_dbg got %h exp 1234", dbg_data); end
      vec++; if (busy_vec !== 8'h0) begin err++; $display("FAIL basic_busy got %h exp 00", busy_vec); end
      tick();
   endtask

   task automatic test_bypass();
      wr_en = 1; wr_addr = 5; wr_data = 16'h5555;
      @(negedge clk); model_upd(); tick();
      wr_data = 16'hBEEF; rd1_addr = 5; dbg_addr = 5;
      @(negedge clk);
      vec++; if (rd1_data !== 16'hBEEF) begin err++; $display("FAIL bypass_rd1 got %h exp beef", rd1_data); end
      vec++; if (dbg_data !== 16'h5555) begin err++; $display("FAIL bypass_dbg got %h exp 5555", dbg_data); end
      vec++; if (b_rd1_data !== 16'h5555) begin err++; $display("FAIL nobypass_rd1 got %h exp 5555", b_rd1_data); end
      model_upd(); tick();
      wr_en = 0;
      @(negedge clk);
      vec++; if (b_rd1_data !== 16'hBEEF) begin err++; $display("FAIL nobypass_after got %h exp beef", b_rd1_data); end
      tick();
   endtask

   task automatic test_scoreboard();
      idle_in();
      iss_en = 1; iss_addr = 2; rd0_addr = 2;
      @(negedge clk);
      vec++; if (rd0_busy !== 1'b0) begin err++; $display("FAIL sb_pre got %b exp 0", rd0_busy); end
      model_upd(); tick();
      wr_en = 1; wr_addr = 2; wr_data = 16'h0222;
      @(negedge clk);
      vec++; if (rd0_busy !== 1'b0) begin err++; $display("FAIL sb_mask got %b exp 0", rd0_busy); end
      vec++; if (b_rd0_busy !== 1'b1) begin err++; $display("FAIL sb_nomask got %b exp 1", b_rd0_busy); end
      model_upd(); tick();
      iss_en = 0;
      @(negedge clk);
      vec++; if (busy_vec[2] !== 1'b1) begin err++; $display("FAIL sb_issue_wins got %b exp 1", busy_vec[2]); end
      vec++; if (rd0_busy !== 1'b0) begin err++; $display("FAIL sb_mask2 got %b exp 0", rd0_busy); end
      model_upd(); tick();
      wr_en = 0;
      @(negedge clk);
      vec++; if (busy_vec !== 8'h00 || rd0_busy !== 1'b0) begin err++;
         $display("FAIL sb_clear got %h/%b exp 00/0", busy_vec, rd0_busy); end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 16'($urandom);
         iss_en = 1'($urandom); iss_addr = 3'($urandom);
         rd0_addr = 3'($urandom); rd1_addr = (n % 3 == 0) ? wr_addr : 3'($urandom); dbg_addr = 3'($urandom);
         @(negedge clk);
         vec++; if (rd0_data !== ((wr_en && wr_addr == rd0_addr) ? wr_data : m_r[rd0_addr])) begin err++;
            $display("FAIL rnd_rd0 got %h exp %h", rd0_data, (wr_en && wr_addr == rd0_addr) ? wr_data : m_r[rd0_addr]); end
         vec++; if (rd1_data !== ((wr_en && wr_addr == rd1_addr) ? wr_data : m_r[rd1_addr])) begin err++;
            $display("FAIL rnd_rd1 got %h exp %h", rd1_data, (wr_en && wr_addr == rd1_addr) ? wr_data : m_r[rd1_addr]); end
         vec++; if (b_rd0_data !== m_r[rd0_addr]) begin err++;
            $display("FAIL rnd_nb_rd0 got %h exp %h", b_rd0_data, m_r[rd0_addr]); end
         vec++; if (rd1_busy !== (m_busy[rd1_addr] && !(wr_en && wr_addr == rd1_addr))) begin err++;
            $display("FAIL rnd_busy1 got %b exp %b", rd1_busy, m_busy[rd1_addr] && !(wr_en && wr_addr == rd1_addr)); end
         vec++; if (dbg_data !== m_r[dbg_addr] || busy_vec !== m_busy) begin err++;
            $display("FAIL rnd_state got %h/%h exp %h/%h", dbg_data, busy_vec, m_r[dbg_addr], m_busy); end
         model_upd(); tick();
      end
      idle_in();
   endtask

   task automatic test_save();
      int beat = 0, cyc = 0;
      bit ld = 1, hs = 0;
      logic [15:0] exp_d;
      idle_in();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_addr = 3'(i); wr_data = 16'h1000 + 16'(i);
         @(negedge clk); model_upd(); tick();
      end
      wr_en = 0; ctx_save = 1;
      @(negedge clk); tick();
      ctx_save = 0;
      while (beat < 8 && cyc < 200) begin
         so_ready = 1'($urandom);
         wr_en = (beat == 4 && ld); wr_addr = 4; wr_data = 16'hAAAA;
         @(negedge clk);
         exp_d = (beat == 4) ? 16'hAAAA : 16'h1000 + 16'(beat);
         vec++; if (ctx_busy !== 1'b1 || so_valid !== !ld) begin err++;
            $display("FAIL save_ctl beat %0d got busy %b valid %b exp 1 %b", beat, ctx_busy, so_valid, !ld); end
         if (so_valid) begin
            vec++; if (so_addr !== 3'(beat) || so_data !== exp_d) begin err++;
               $display("FAIL save_beat got %0d:%h exp %0d:%h", so_addr, so_data, beat, exp_d); end
         end
         hs = so_valid && so_ready;
         model_upd(); tick();
         ld = hs; cyc++;
         if (hs) beat++;
      end
      so_ready = 0; wr_en = 0;
      @(negedge clk);
      vec++; if (beat != 8 || ctx_busy !== 1'b0 || cyc < 16) begin err++;
         $display("FAIL save_end got beats %0d busy %b cycles %0d exp 8 0 >=16", beat, ctx_busy, cyc); end
      tick();
   endtask

   task automatic test_restore();
      int beat = 0, cyc = 0;
      idle_in();
      iss_en = 1; iss_addr = 1;
      @(negedge clk); model_upd(); tick();
      iss_addr = 6;
      @(negedge clk); model_upd(); tick();
      iss_en = 0; ctx_restore = 1;
      @(negedge clk);
      vec++; if (busy_vec !== 8'h42) begin err++; $display("FAIL rst_pre_busy got %h exp 42", busy_vec); end
      tick();
      ctx_restore = 0;
      while (beat < 8 && cyc < 200) begin
         si_valid = 1'($urandom); si_data = 16'hF000 + 16'(beat);
         wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 16'($urandom); rd0_addr = wr_addr;
         iss_en = 1'($urandom); iss_addr = 3'($urandom);
         @(negedge clk);
         vec++; if (si_ready !== 1'b1 || ctx_busy !== 1'b1 || wr_drop !== wr_en) begin err++;
            $display("FAIL restore_ctl got rdy %b busy %b drop %b exp 1 1 %b", si_ready, ctx_busy, wr_drop, wr_en); end
         vec++; if (rd0_data !== m_r[rd0_addr]) begin err++;
            $display("FAIL restore_rd0 got %h exp %h", rd0_data, m_r[rd0_addr]); end
         if (si_valid) begin
            m_r[beat] = si_data; m_busy[beat] = 1'b0; beat++;
         end
         tick(); cyc++;
      end
      idle_in();
      @(negedge clk);
      vec++; if (beat != 8 || ctx_busy !== 1'b0 || si_ready !== 1'b0 || busy_vec !== 8'h00 || cyc < 8) begin err++;
         $display("FAIL restore_end got beats %0d busy %b rdy %b vec %h exp 8 0 0 00", beat, ctx_busy, si_ready, busy_vec); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #0.1;
         vec++; if (dbg_data !== 16'hF000 + 16'(i)) begin err++;
            $display("FAIL restore_r%0d got %h exp %h", i, dbg_data, 16'hF000 + 16'(i)); end
      end
      tick();
   endtask

   task automatic test_reset_mid_save();
      bit hit = 0;
      idle_in();
      iss_en = 1; iss_addr = 7;
      @(negedge clk); model_upd(); tick();
      iss_en = 0; ctx_save = 1;
      @(negedge clk); tick();
      ctx_save = 0; so_ready = 1;
      for (int c = 0; c < 50 && !hit; c++) begin
         @(negedge clk);
         if (so_valid && so_addr == 3) begin
            vec++; if (so_data !== 16'hF003) begin err++; $display("FAIL midsave_beat3 got %h exp f003", so_data); end
            rst = 1;
            #1;
            hit = 1;
         end else tick();
      end
      vec++; if (!hit || so_valid !== 1'b0 || ctx_busy !== 1'b0 || busy_vec !== 8'h00) begin err++;
         $display("FAIL midsave_reset got hit %b valid %b busy %b vec %h exp 1 0 0 00", hit, so_valid, ctx_busy, busy_vec); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #0.1;
         vec++; if (dbg_data !== 16'h0) begin err++; $display("FAIL midsave_r%0d got %h exp 0000", i, dbg_data); end
      end
      model_rst();
      @(negedge clk);
      rst = 0;
      so_ready = 0;
      tick();
   endtask

   task automatic test_both();
      bit done = 0;
      idle_in();
      ctx_save = 1; ctx_restore = 1;
      @(negedge clk); tick();
      ctx_save = 0; ctx_restore = 0;
      @(negedge clk);
      vec++; if (ctx_busy !== 1'b1 || si_ready !== 1'b0 || so_valid !== 1'b0) begin err++;
         $display("FAIL both_first got busy %b rdy %b valid %b exp 1 0 0", ctx_busy, si_ready, so_valid); end
      tick();
      @(negedge clk);
      vec++; if (so_valid !== 1'b1 || so_addr !== 3'd0 || so_data !== 16'h0) begin err++;
         $display("FAIL both_beat0 got %b %0d:%h exp 1 0:0000", so_valid, so_addr, so_data); end
      so_ready = 1;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         @(negedge clk);
         done = !ctx_busy;
      end
      vec++; if (!done) begin err++; $display("FAIL both_timeout got busy %b exp 0", ctx_busy); end
      so_ready = 0;
      tick();
   endtask

   initial begin
      idle_in();
      model_rst();
      test_reset();
      test_basic();
      test_bypass();
      test_scoreboard();
      test_random();
      test_save();
      test_restore();
      test_reset_mid_save();
      test_both();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/lc3_regfile_ctx.md
# lc3_regfile_ctx

Parametrised, scoreboarded register file for the pipelined LC-3 datapath, generalising the single-cycle register file in width and depth. It provides two bypassed read ports plus a debug port, per-register busy tracking for hazard stalls, and a context save/restore engine that streams the whole register set out to, or in from, the interrupt/trap controller over valid/ready handshakes. It sits between decode (reads, issue) and writeback (writes).

## Interface
- DATA_W, 16, register width
- NREG, 8, number of registers (power of two, >= 2)
- AW, $clog2(NREG), register address width
- BYPASS, 1, 1 = same-cycle write is forwarded to read ports

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en / wr_addr / wr_data  in  1 / AW / DATA_W  writeback port
- wr_drop  out  1  wr_en was ignored this cycle (RESTORE active)
- rd0_addr, rd1_addr  in  AW  read addresses
- rd0_data, rd1_data  out  DATA_W  read data (combinational)
- rd0_busy, rd1_busy  out  1  addressed register has a pending write
- dbg_addr  in  AW;  dbg_data  out  DATA_W  raw register value, never bypassed
- iss_en / iss_addr  in  1 / AW  instruction issued that will write iss_addr
- busy_vec  out  NREG  scoreboard
- ctx_save, ctx_restore  in  1  start request (single-cycle pulse)
- ctx_busy  out  1  engine not IDLE
- so_valid out 1, so_ready in 1, so_addr out AW, so_data out DATA_W  save stream
- si_valid in 1, si_ready out 1, si_data in DATA_W  restore stream

## Operation
- Reads: rdN_data = R[rdN_addr]; if BYPASS and wr_en accepted and wr_addr==rdN_addr, rdN_data = wr_data.
- rdN_busy = busy_vec[rdN_addr], masked to 0 when BYPASS and an accepted write to that address occurs in the same cycle.
- Scoreboard, next-state per bit: accepted iss_en sets; accepted wr_en clears; simultaneous set and clear on the same register leaves it set (the new issue wins).
- FSM states: IDLE, SAVE_LD, SAVE_TX, RESTORE.
- IDLE: ctx_save goes to SAVE_LD with idx=0. Else ctx_restore goes to RESTORE with idx=0. Save wins if both are asserted. Requests are ignored outside IDLE.
- SAVE_LD: latch so_data <= R[idx], using wr_data if a same-cycle write targets idx; latch so_addr <= idx; go to SAVE_TX.
- SAVE_TX: so_valid=1. so_data and so_addr are held stable until so_ready. On handshake: if idx==NREG-1, go to IDLE; else idx++ and go to SAVE_LD. Normal writes and issues continue during SAVE.
- RESTORE: si_ready=1. On si_valid: R[idx] <= si_data and busy[idx] cleared; if idx==NREG-1, go to IDLE; else idx++.
- During RESTORE: wr_en is ignored and wr_drop = wr_en (combinational); iss_en is ignored. Read ports still operate; bypass applies only to accepted writes.
- idx wraps never; the terminal transfer always returns to IDLE.

## Timing
- Reset: all R = 0, busy_vec = 0, state IDLE, idx = 0, so_valid = 0, so_data = 0, so_addr = 0, si_ready = 0, ctx_busy = 0, wr_drop = 0.
- Reset mid-save or mid-restore returns immediately to IDLE. Partially restored registers are cleared to 0.
- Writes and scoreboard updates take effect at the next rising edge. Reads are zero-latency.
- ctx_busy rises the cycle after an accepted request and falls the cycle after the final handshake.
- Save takes at least 2·NREG cycles (one LD plus one TX per register) with so_ready held high. Restore takes at least NREG cycles with si_valid held high.
- so_valid is never asserted in consecutive cycles across registers, because SAVE_LD intervenes.

## Test plan
- Reset, then write R3=0x1234; next cycle rd0_addr=3 -> rd0_data=0x1234, dbg_data(3)=0x1234, busy_vec=0.
- BYPASS=1: wr_en R5=0xBEEF with rd1_addr=5 in the same cycle -> rd1_data=0xBEEF, dbg_data(5) still old value. BYPASS=0 -> old value.
- iss_en R2, then in the same cycle wr_en R2 plus iss_en R2 -> busy_vec[2] stays 1. A later wr_en R2 alone -> busy_vec[2]=0. rd0_busy follows, masked on the clearing cycle.
- Load R0..R7=0x1000+i, pulse ctx_save, so_ready toggling 1-0-1 -> 8 beats with so_addr 0..7 and so_data 0x1000..0x1007, stable while stalled; ctx_busy drops after beat 7. A write to R4=0xAAAA before its SAVE_LD -> beat 4 carries 0xAAAA.
- Pulse ctx_restore, stream 0xF000+i with gaps in si_valid -> R[i]=0xF000+i. wr_en during RESTORE -> wr_drop=1 and register unchanged. Busy bits of restored registers cleared.
- Assert rst midway through a save at beat 3 -> so_valid=0, ctx_busy=0, all R=0. Simultaneous ctx_save and ctx_restore -> save performed.
